// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-output programmable divided clock generator
// Per-channel phase offsets are built only when CLKGEN_PHASE_EN is defined.
module clk_gen_multi #(
    parameter int NUM_CLKS    = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 16,
    localparam int SEL_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1,
    localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                restart,
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_phase,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outclk_en,
    output logic                locked
);

    typedef enum logic {SYNC, RUN} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]    per_q  [NUM_CLKS];
    logic [CNT_W-1:0]    high_q [NUM_CLKS];
    logic [CNT_W-1:0]    cnt_q  [NUM_CLKS];
    logic [CNT_W-1:0]    base_cnt [NUM_CLKS];
    logic [CNT_W-1:0]    cnt_nxt  [NUM_CLKS];
    logic [NUM_CLKS-1:0] out_nxt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic                cfg_valid;
    logic                realign;

`ifdef CLKGEN_PHASE_EN
    logic [CNT_W-1:0]    phase_q  [NUM_CLKS];
    logic [CNT_W-1:0]    dly_q    [NUM_CLKS];
    logic [CNT_W-1:0]    base_dly [NUM_CLKS];
    logic [CNT_W-1:0]    dly_nxt  [NUM_CLKS];
`else
    logic unused_phase;
    assign unused_phase = ^cfg_phase;
`endif

    assign cfg_valid = cfg_wr && ({1'b0, cfg_sel} < (SEL_W + 1)'(NUM_CLKS));
    assign realign   = restart || cfg_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        if (realign) state_nxt = SYNC;
    end

    // While in SYNC the counters are treated as freshly loaded, so the edge
    // leaving SYNC already presents the first RUN cycle's output.
    always_comb begin
        for (int i = 0; i < NUM_CLKS; i++) begin
            base_cnt[i] = (state == SYNC) ? '0 : cnt_q[i];
            cnt_nxt[i]  = base_cnt[i];
            out_nxt[i]  = 1'b0;
`ifdef CLKGEN_PHASE_EN
            if (state == SYNC)
                base_dly[i] = (phase_q[i] >= per_q[i]) ? per_q[i] - CNT_W'(1) : phase_q[i];
            else
                base_dly[i] = dly_q[i];
            dly_nxt[i] = base_dly[i];
            if (base_dly[i] != '0) begin
                dly_nxt[i] = base_dly[i] - CNT_W'(1);
            end else
`endif
            begin
                out_nxt[i] = (per_q[i] > CNT_W'(1)) && (base_cnt[i] < high_q[i]);
                cnt_nxt[i] = (base_cnt[i] >= per_q[i] - CNT_W'(1)) ? '0 : base_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outclk    <= '0;
            outclk_en <= '0;
            locked    <= 1'b0;
            lock_cnt  <= '0;
            for (int i = 0; i < NUM_CLKS; i++) begin
                per_q[i]   <= CNT_W'(2);
                high_q[i]  <= CNT_W'(1);
                cnt_q[i]   <= '0;
`ifdef CLKGEN_PHASE_EN
                phase_q[i] <= '0;
                dly_q[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                if (cfg_valid && cfg_sel == SEL_W'(i)) begin
                    per_q[i]   <= cfg_div;
                    high_q[i]  <= cfg_high;
`ifdef CLKGEN_PHASE_EN
                    phase_q[i] <= cfg_phase;
`endif
                end
            end
            if (realign) begin
                outclk    <= '0;
                outclk_en <= '0;
                locked    <= 1'b0;
                lock_cnt  <= '0;
            end else begin
                outclk    <= out_nxt;
                outclk_en <= out_nxt & ~outclk;
                for (int i = 0; i < NUM_CLKS; i++) begin
                    cnt_q[i] <= cnt_nxt[i];
`ifdef CLKGEN_PHASE_EN
                    dly_q[i] <= dly_nxt[i];
`endif
                end
                if (state == RUN) begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) locked   <= 1'b1;
                    else                                      lock_cnt <= lock_cnt + LOCK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - scoreboard bench for clk_gen_multi against a closed-form model
module tb_clk_gen_multi;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int LC = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         restart = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [1:0]   cfg_sel = '0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic [W-1:0] cfg_phase = '0;
    logic [N-1:0] outclk;
    logic [N-1:0] outclk_en;
    logic         locked;

    clk_gen_multi #(.NUM_CLKS(N), .CNT_W(W), .LOCK_CYCLES(LC)) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .cfg_wr(cfg_wr),
        .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    int m_p [N];
    int m_h [N];
    int m_f [N];
    int k;  // cycles since the first RUN cycle; -1 while in SYNC

    logic [2*N:0] exp_q [$];
    string        tag_q [$];

    // Output level of one channel k cycles into RUN.
    function automatic bit mout(int kk, int p, int h, int f);
        int ff;
        if (kk < 0 || p < 2) return 1'b0;
`ifdef CLKGEN_PHASE_EN
        ff = (f >= p) ? p - 1 : f;
`else
        ff = 0;
`endif
        if (kk < ff) return 1'b0;
        return ((kk - ff) % p) < h;
    endfunction

    function automatic logic [2*N:0] expv();
        logic [N-1:0] o, e;
        for (int i = 0; i < N; i++) begin
            o[i] = mout(k, m_p[i], m_h[i], m_f[i]);
            e[i] = o[i] && !mout(k - 1, m_p[i], m_h[i], m_f[i]);
        end
        return {o, e, (k >= LC)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_p[i] = 2; m_h[i] = 1; m_f[i] = 0;
        end
        k = -1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Called at a negedge; drives one cycle, records its expectation, returns at the next negedge.
    task automatic drive(bit w, int sel, int d, int h, int f, bit rs, string tag);
        cfg_wr = w; cfg_sel = 2'(sel); cfg_div = W'(d); cfg_high = W'(h);
        cfg_phase = W'(f); restart = rs;
        if (w && sel < N) begin
            m_p[sel] = d; m_h[sel] = h; m_f[sel] = f;
        end
        if (rs || (w && sel < N)) k = -1;
        else                      k = k + 1;
        exp_q.push_back(expv());
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0, tag);
    endtask

    initial begin
        logic [2*N:0] e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL no_expectation got=%b want=queued_entry", {outclk, outclk_en, locked});
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if ({outclk, outclk_en, locked} !== e) begin
                        bad++;
                        $display("FAIL %s t=%0t got clk=%b en=%b lock=%b want clk=%b en=%b lock=%b",
                                 t, $time, outclk, outclk_en, locked, e[2*N:N+1], e[N:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outclk", 32'(outclk), 0);
        check("reset_en", 32'(outclk_en), 0);
        check("reset_locked", 32'(locked), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(24, "defaults");

        drive(1'b1, 0, 5, 2, 0, 1'b0, "wr_ch0");
        drive(1'b1, 1, 5, 2, 3, 1'b0, "wr_ch1_in_sync");
        idle(24, "p5_phase");

        drive(1'b1, 2, 3, 1, 1, 1'b0, "wr_midrun");
        idle(22, "relock");

        drive(1'b1, 3, 7, 3, 0, 1'b0, "wr_invalid");
        idle(5, "after_invalid");

        drive(1'b1, 0, 1, 1, 0, 1'b0, "p1");
        idle(8, "p1_low");
        drive(1'b1, 0, 4, 0, 0, 1'b0, "h0");
        idle(8, "h0_low");
        drive(1'b1, 0, 4, 7, 0, 1'b0, "h_ge_p");
        idle(8, "h_ge_p_high");
        drive(1'b1, 0, 4, 2, 9, 1'b0, "f_ge_p");
        idle(8, "f_ge_p_run");

        drive(1'b1, 1, 6, 3, 2, 1'b1, "wr_and_restart");
        idle(6, "single_sync");
        drive(1'b0, 0, 0, 0, 0, 1'b1, "restart");
        idle(20, "after_restart");

        #2 reset_n = 1'b0;
        #1;
        mon_en = 1'b0;
        check("async_outclk", 32'(outclk), 0);
        check("async_en", 32'(outclk_en), 0);
        check("async_locked", 32'(locked), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(20, "reverted_defaults");

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(11) == 0)
                drive(1'b1, $urandom_range(3), $urandom_range(9), $urandom_range(10),
                      $urandom_range(10), ($urandom_range(3) == 0), "rand_wr");
            else if ($urandom_range(29) == 0)
                drive(1'b0, 0, 0, 0, 0, 1'b1, "rand_restart");
            else
                drive(1'b0, 0, 0, 0, 0, 1'b0, "rand_idle");
        end

        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
